// File: rtl/serial_pattern_detector_if.sv
// Bus bundle for serial_pattern_detector.
//   master : stream/control source (drives bit_in, bit_valid, load_pattern,
//            pattern_in, clear_count; observes detector results)
//   slave  : the detector itself (drives window, armed, match, match_count,
//            count_sat)
interface serial_pattern_detector_if #(
   parameter int WIDTH   = 6,
   parameter int COUNT_W = 8
);
   logic               bit_in;
   logic               bit_valid;
   logic               load_pattern;
   logic [WIDTH-1:0]   pattern_in;
   logic               clear_count;
   logic [WIDTH-1:0]   window;
   logic               armed;
   logic               match;
   logic [COUNT_W-1:0] match_count;
   logic               count_sat;

   modport master (
      output bit_in, bit_valid, load_pattern, pattern_in, clear_count,
      input  window, armed, match, match_count, count_sat
   );

   modport slave (
      input  bit_in, bit_valid, load_pattern, pattern_in, clear_count,
      output window, armed, match, match_count, count_sat
   );
endinterface

// File: rtl/serial_pattern_detector.sv
// Serial pattern detector: shifts bit_in into a WIDTH-bit window (MSB oldest)
// and compares it every sampled bit against a programmable pattern. A hit
// gives a one-cycle registered match pulse and bumps a saturating counter.
// Ports:
//   clk   - clock, all state on rising edge
//   reset - synchronous, active-high
//   bus   - serial_pattern_detector_if.slave:
//           in : bit_in, bit_valid, load_pattern, pattern_in, clear_count
//           out: window, armed, match, match_count, count_sat
module serial_pattern_detector #(
   parameter int               WIDTH       = 6,
   parameter int               COUNT_W     = 8,
   parameter bit               OVERLAP     = 1'b1,
   parameter logic [WIDTH-1:0] PATTERN_RST = '0
) (
   input  logic                      clk,
   input  logic                      reset,
   serial_pattern_detector_if.slave  bus
);
   localparam int                FILL_W = $clog2(WIDTH + 1);
   localparam logic [FILL_W-1:0] FULL   = FILL_W'(WIDTH);

   typedef enum logic {S_FILL, S_ARMED} state_t;

   state_t              state_q, state_d;
   logic [FILL_W-1:0]   fill_q, fill_d, fill_inc;
   logic [WIDTH-1:0]    window_q, window_d, next_window;
   logic [WIDTH-1:0]    pattern_q, pattern_d;
   logic [COUNT_W-1:0]  count_q, count_d;
   logic                match_q, hit;

   // State register (reset wins over everything, including a pending hit)
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FILL;
         fill_q    <= '0;
         window_q  <= '0;
         pattern_q <= PATTERN_RST;
         count_q   <= '0;
         match_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         fill_q    <= fill_d;
         window_q  <= window_d;
         pattern_q <= pattern_d;
         count_q   <= count_d;
         match_q   <= hit;
      end
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      fill_d      = fill_q;
      window_d    = window_q;
      pattern_d   = pattern_q;
      count_d     = count_q;
      hit         = 1'b0;
      fill_inc    = (fill_q == FULL) ? FULL : fill_q + 1'b1;
      next_window = {window_q[WIDTH-2:0], bus.bit_in};

      if (bus.load_pattern) begin
         // restart detection against the new pattern; a concurrent bit is dropped
         pattern_d = bus.pattern_in;
         window_d  = '0;
         fill_d    = '0;
         state_d   = S_FILL;
      end else if (bus.bit_valid) begin
         window_d = next_window;
         hit      = (fill_inc == FULL) && (&(next_window ~^ pattern_q));
         // non-overlapping mode: the matched bits must be fully replaced first
         fill_d   = (hit && !OVERLAP) ? '0 : fill_inc;
         state_d  = (fill_d == FULL) ? S_ARMED : S_FILL;
      end

      // clear beats a concurrent increment; the match pulse is unaffected
      if (bus.clear_count)
         count_d = '0;
      else if (hit && (count_q != '1))
         count_d = count_q + 1'b1;
   end

   // Outputs
   always_comb begin
      bus.window      = window_q;
      bus.armed       = (state_q == S_ARMED);
      bus.match       = match_q;
      bus.match_count = count_q;
      bus.count_sat   = &count_q;
   end
endmodule

// File: tb/tb_serial_pattern_detector.sv
module tb_serial_pattern_detector;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   serial_pattern_detector_if #(.WIDTH(6), .COUNT_W(8)) if0 ();
   serial_pattern_detector_if #(.WIDTH(6), .COUNT_W(8)) if1 ();

   serial_pattern_detector #(.WIDTH(6), .COUNT_W(8), .OVERLAP(1'b1), .PATTERN_RST(6'b000000))
      dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
   serial_pattern_detector #(.WIDTH(6), .COUNT_W(8), .OVERLAP(1'b0), .PATTERN_RST(6'b000000))
      dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

   typedef struct {
      bit         dut;
      string      name;
      logic       match;
      logic [5:0] window;
      logic       armed;
      logic [7:0] count;
      logic       sat;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Monitor: one expected entry per clock, compared just after the edge
   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         exp_t e;
         logic [16:0] act, req;
         e = q.pop_front();
         if (e.dut) act = {if1.match, if1.window, if1.armed, if1.match_count, if1.count_sat};
         else       act = {if0.match, if0.window, if0.armed, if0.match_count, if0.count_sat};
         req = {e.match, e.window, e.armed, e.count, e.sat};
         vectors++;
         if (act !== req) begin
            miscompares++;
            $display("FAIL %s dut%0d: got m=%b w=%b a=%b c=%0d s=%b, want m=%b w=%b a=%b c=%0d s=%b",
                     e.name, e.dut, act[16], act[15:10], act[9], act[8:1], act[0],
                     e.match, e.window, e.armed, e.count, e.sat);
         end
      end
   end

   // Drive one cycle of inputs to both DUTs and queue the outputs expected after the edge
   task automatic step(input string nm, input bit d, input bit rst, input bit ld,
                       input logic [5:0] pat, input bit bv, input bit b, input bit clr,
                       input bit m, input logic [5:0] w, input bit a, input logic [7:0] c);
      exp_t e;
      @(negedge clk);
      reset = rst;
      if0.load_pattern = ld; if1.load_pattern = ld;
      if0.pattern_in   = pat; if1.pattern_in  = pat;
      if0.bit_valid    = bv;  if1.bit_valid   = bv;
      if0.bit_in       = b;   if1.bit_in      = b;
      if0.clear_count  = clr; if1.clear_count = clr;
      e.dut = d; e.name = nm; e.match = m; e.window = w; e.armed = a;
      e.count = c; e.sat = (c == 8'hFF);
      q.push_back(e);
   endtask

   // shorthand: a plain data bit, no load/clear/reset
   task automatic bitv(input string nm, input bit d, input bit b,
                       input bit m, input logic [5:0] w, input bit a, input logic [7:0] c);
      step(nm, d, 0, 0, 6'b0, 1, b, 0, m, w, a, c);
   endtask

   task automatic rst_load(input string nm, input bit d, input logic [5:0] pat);
      step({nm, "_rst"},  d, 1, 0, 6'b0, 0, 0, 0, 0, 6'b0, 0, 8'd0);
      step({nm, "_load"}, d, 0, 1, pat,  0, 0, 0, 0, 6'b0, 0, 8'd0);
   endtask

   initial begin
      reset = 1'b1;
      if0.bit_in = 0; if0.bit_valid = 0; if0.load_pattern = 0; if0.pattern_in = 0; if0.clear_count = 0;
      if1.bit_in = 0; if1.bit_valid = 0; if1.load_pattern = 0; if1.pattern_in = 0; if1.clear_count = 0;

      // basic detection 101101
      rst_load("basic", 0, 6'b101101);
      bitv("basic_b1", 0, 1, 0, 6'b000001, 0, 0);
      bitv("basic_b2", 0, 0, 0, 6'b000010, 0, 0);
      bitv("basic_b3", 0, 1, 0, 6'b000101, 0, 0);
      bitv("basic_b4", 0, 1, 0, 6'b001011, 0, 0);
      bitv("basic_b5", 0, 0, 0, 6'b010110, 0, 0);
      bitv("basic_b6", 0, 1, 1, 6'b101101, 1, 1);
      step("basic_idle", 0, 0, 0, 6'b0, 0, 0, 0, 0, 6'b101101, 1, 8'd1);

      // overlapping 10101010
      rst_load("ovl", 0, 6'b101010);
      bitv("ovl_b1", 0, 1, 0, 6'b000001, 0, 0);
      bitv("ovl_b2", 0, 0, 0, 6'b000010, 0, 0);
      bitv("ovl_b3", 0, 1, 0, 6'b000101, 0, 0);
      bitv("ovl_b4", 0, 0, 0, 6'b001010, 0, 0);
      bitv("ovl_b5", 0, 1, 0, 6'b010101, 0, 0);
      bitv("ovl_b6", 0, 0, 1, 6'b101010, 1, 1);
      bitv("ovl_b7", 0, 1, 0, 6'b010101, 1, 1);
      bitv("ovl_b8", 0, 0, 1, 6'b101010, 1, 2);

      // non-overlapping 10101010 on the OVERLAP=0 instance
      rst_load("novl", 1, 6'b101010);
      bitv("novl_b1", 1, 1, 0, 6'b000001, 0, 0);
      bitv("novl_b2", 1, 0, 0, 6'b000010, 0, 0);
      bitv("novl_b3", 1, 1, 0, 6'b000101, 0, 0);
      bitv("novl_b4", 1, 0, 0, 6'b001010, 0, 0);
      bitv("novl_b5", 1, 1, 0, 6'b010101, 0, 0);
      bitv("novl_b6", 1, 0, 1, 6'b101010, 0, 1);
      bitv("novl_b7", 1, 1, 0, 6'b010101, 0, 1);
      bitv("novl_b8", 1, 0, 0, 6'b101010, 0, 1);

      // saturation: reset pattern is all zeros, 305 zero bits
      step("sat_rst", 0, 1, 0, 6'b0, 0, 0, 0, 0, 6'b0, 0, 8'd0);
      for (int i = 1; i <= 305; i++) begin
         int c;
         c = (i >= 6) ? ((i - 5 > 255) ? 255 : i - 5) : 0;
         bitv($sformatf("sat_b%0d", i), 0, 0, (i >= 6), 6'b0, (i >= 6), 8'(c));
      end
      // clear together with a hit: count zeroed, pulse still present
      step("sat_clr_hit", 0, 0, 0, 6'b0, 1, 0, 1, 1, 6'b0, 1, 8'd0);
      step("sat_clr_idle", 0, 0, 0, 6'b0, 0, 0, 1, 0, 6'b0, 1, 8'd0);
      bitv("sat_after", 0, 0, 1, 6'b0, 1, 1);

      // load mid-stream drops the concurrent bit
      rst_load("ldmid", 0, 6'b101101);
      bitv("ldmid_b1", 0, 1, 0, 6'b000001, 0, 0);
      bitv("ldmid_b2", 0, 0, 0, 6'b000010, 0, 0);
      bitv("ldmid_b3", 0, 1, 0, 6'b000101, 0, 0);
      bitv("ldmid_b4", 0, 1, 0, 6'b001011, 0, 0);
      step("ldmid_load", 0, 0, 1, 6'b101101, 1, 0, 0, 0, 6'b0, 0, 8'd0);
      bitv("ldmid_c1", 0, 1, 0, 6'b000001, 0, 0);
      bitv("ldmid_c2", 0, 0, 0, 6'b000010, 0, 0);
      bitv("ldmid_c3", 0, 1, 0, 6'b000101, 0, 0);
      bitv("ldmid_c4", 0, 1, 0, 6'b001011, 0, 0);
      bitv("ldmid_c5", 0, 0, 0, 6'b010110, 0, 0);
      bitv("ldmid_c6", 0, 1, 1, 6'b101101, 1, 1);

      // reset on what would be the completing bit
      rst_load("rstmid", 0, 6'b101101);
      bitv("rstmid_b1", 0, 1, 0, 6'b000001, 0, 0);
      bitv("rstmid_b2", 0, 0, 0, 6'b000010, 0, 0);
      bitv("rstmid_b3", 0, 1, 0, 6'b000101, 0, 0);
      bitv("rstmid_b4", 0, 1, 0, 6'b001011, 0, 0);
      bitv("rstmid_b5", 0, 0, 0, 6'b010110, 0, 0);
      step("rstmid_rst", 0, 1, 0, 6'b0, 1, 1, 0, 0, 6'b0, 0, 8'd0);
      step("rstmid_idle", 0, 0, 0, 6'b0, 0, 0, 0, 0, 6'b0, 0, 8'd0);

      // gaps inside a matching sequence
      step("gap_load", 0, 0, 1, 6'b101101, 0, 0, 0, 0, 6'b0, 0, 8'd0);
      bitv("gap_b1", 0, 1, 0, 6'b000001, 0, 0);
      bitv("gap_b2", 0, 0, 0, 6'b000010, 0, 0);
      bitv("gap_b3", 0, 1, 0, 6'b000101, 0, 0);
      for (int g = 0; g < 3; g++)
         step($sformatf("gap_idle%0d", g), 0, 0, 0, 6'b0, 0, 1, 0, 0, 6'b000101, 0, 8'd0);
      bitv("gap_b4", 0, 1, 0, 6'b001011, 0, 0);
      bitv("gap_b5", 0, 0, 0, 6'b010110, 0, 0);
      bitv("gap_b6", 0, 1, 1, 6'b101101, 1, 1);
      step("gap_end", 0, 0, 0, 6'b0, 0, 0, 0, 0, 6'b101101, 1, 8'd1);

      // drain the scoreboard, bounded
      begin
         int budget = 20;
         while (q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
         end
         if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
